ahb_mem_slave: RTL and testbench
================================

# ahb_mem_slave

AHB 2.0 memory responder sitting on the slave side of the arbiter/decoder fabric, completing transfers issued by granted masters. It decodes one address window, stores data in an internal word array, and inserts programmable wait states. Illegal accesses get the two-cycle ERROR response. It is the reference target the master agents and arbiter are exercised against.

## Interface
- BASE_ADDR, 32'h0000_0000, window base; must be aligned to MEM_DEPTH*4
- MEM_DEPTH, 256, number of 32-bit words (power of two)
- WAIT_STATES, 0, data-phase wait cycles per OKAY transfer (0..15)
- hclk  in  1  clock, all logic on rising edge
- hreset  in  1  synchronous, active-high reset
- hsel  in  1  slave select from decoder
- haddr  in  32  address
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  in  1  1=write
- hsize  in  3  BYTE=0, HALF=1, WORD=2
- hburst  in  3  burst type (informational only, no behaviour)
- hwdata  in  32  write data (data phase)
- hmaster  in  4  current master id (informational only)
- hmastlock  in  1  locked sequence (informational only)
- hready_in  in  1  bus-level hready from mux
- hready  out  1  slave ready
- hresp  out  2  OKAY=0, ERROR=1 (RETRY/SPLIT never driven)
- hrdata  out  32  read data

## Operation
- Address phase accepted on a rising edge with hsel=1, hready_in=1, htrans[1]=1 (NONSEQ/SEQ). IDLE/BUSY or hsel=0: nothing accepted; zero-wait OKAY.
- Error if any: hsize>WORD; HALF with haddr[0]=1; WORD with haddr[1:0]!=0; (haddr-BASE_ADDR) >= MEM_DEPTH*4 or haddr<BASE_ADDR.
- FSM: IDLE, WAIT, ERR1, ERR2.
  - IDLE: hready=1, hresp=OKAY. Accepted legal transfer with wait count 0 -> stays IDLE (completes next edge); count>0 -> WAIT; illegal -> ERR1.
  - WAIT: hready=0, hresp=OKAY; counter decrements; at 1 -> IDLE.
  - ERR1: hready=0, hresp=ERROR -> ERR2.
  - ERR2: hready=1, hresp=ERROR; may accept next address phase (same rules as IDLE).
- Writes: committed on the completion edge (hready=1 edge) from latched address/size using hwdata; little-endian lanes: BYTE lane haddr[1:0], HALF lanes haddr[1]*2+{0,1}. Errored transfers never write.
- Reads: hrdata holds the full addressed word while hready=1 for that transfer; 0 at all other times.
- Read accepted on the edge a write completes to the same word: hrdata returns the merged new value (forwarding).
- Memory array is not reset.

## Timing
- Reset: hready=1, hresp=OKAY, hrdata=0, FSM=IDLE, counter=0; reset wins over a completing write (no write).
- Legal transfer accepted at edge N: hready=0 for WAIT_STATES cycles, completes at edge N+1+WAIT_STATES.
- Error accepted at edge N: ERROR/hready=0 in cycle N..N+1, ERROR/hready=1 in N+1..N+2, completes edge N+2.
- Back-to-back pipelined zero-wait transfers sustain one per cycle.
- Address/control sampled only at acceptance; changes during WAIT ignored.

## Configuration
- AHB_SLV_RAND_WAIT_EN defined: per-transfer wait count = lfsr % (WAIT_STATES+1), 8-bit LFSR x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, advances once per accepted legal transfer.
- Undefined: wait count is fixed at WAIT_STATES.

## Test plan
- WAIT_STATES=0: WORD write 32'hDEADBEEF to BASE+0x10, then read -> hrdata=32'hDEADBEEF, hready never low, hresp=OKAY.
- BYTE writes 8'h11 at +0x21, HALF 16'hA5A5 at +0x22 over zeroed word -> read +0x20 returns 32'hA5A5_1100.
- WAIT_STATES=3: single read -> hready low exactly 3 cycles, data valid on 4th.
- WORD access at +0x02 and at BASE+MEM_DEPTH*4 -> ERROR two-cycle (hready 0 then 1), memory unchanged.
- Write 32'h1234_5678 to +0x40 immediately followed by read of +0x40 -> hrdata=32'h1234_5678 (forwarding).
- hreset asserted in WAIT of a write -> outputs at reset values next cycle, target word unchanged.

Source files
------------

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB 2.0 memory responder with one decoded address window,
// byte/half/word access, programmable data-phase wait states and a
// two-cycle ERROR response for illegal accesses.
// Optional feature: define AHB_SLV_RAND_WAIT_EN for LFSR-randomised wait
// counts in the range 0..WAIT_STATES.
module ahb_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic [3:0]  hmaster,
  input  logic        hmastlock,
  input  logic        hready_in,
  output logic        hready,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] MemBytes = 33'(MEM_DEPTH) << 2;
  localparam logic [1:0]  RespOkay = 2'b00;
  localparam logic [1:0]  RespErr  = 2'b01;

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  state_e          r_state;
  logic [3:0]      r_cnt;
  logic            r_hready;
  logic [1:0]      r_hresp;
  logic            r_pend;   // legal transfer currently in its data phase
  logic            r_write;
  logic [1:0]      r_size;
  logic [1:0]      r_lane;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_mem [MEM_DEPTH];

  logic [31:0]     w_offset;
  logic            w_out_of_range;
  logic            w_misaligned;
  logic            w_illegal;
  logic            w_accept;
  logic            w_complete;
  logic [3:0]      w_wait_cnt;
  logic [3:0]      w_be;
  logic            w_unused;

  assign w_offset       = haddr - BASE_ADDR;
  assign w_out_of_range = (haddr < BASE_ADDR) || ({1'b0, w_offset} >= MemBytes);
  assign w_misaligned   = (hsize > 3'd2) ||
                          ((hsize == 3'd1) && haddr[0]) ||
                          ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign w_illegal      = w_out_of_range | w_misaligned;
  // Only accept while our own data phase is finishing (hready high).
  assign w_accept       = hsel & hready_in & htrans[1] & r_hready;
  assign w_complete     = r_pend & r_hready;

`ifdef AHB_SLV_RAND_WAIT_EN
  logic [7:0] r_lfsr;

  assign w_wait_cnt = 4'(r_lfsr % 8'(WAIT_STATES + 1));

  // LFSR x^8+x^6+x^5+x^4+1, steps once per accepted legal transfer.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_lfsr <= 8'hA5;
    end else if (w_accept && !w_illegal) begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end
`else
  assign w_wait_cnt = 4'(WAIT_STATES);
`endif

  // Little-endian byte enables for the transfer in its data phase.
  always_comb begin
    w_be = 4'b0000;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_lane;
      2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Response FSM with registered hready/hresp and latched address phase.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state  <= StIdle;
      r_cnt    <= 4'd0;
      r_hready <= 1'b1;
      r_hresp  <= RespOkay;
      r_pend   <= 1'b0;
      r_write  <= 1'b0;
      r_size   <= 2'd0;
      r_lane   <= 2'd0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        StIdle, StErr2: begin
          if (w_accept && w_illegal) begin
            r_state  <= StErr1;
            r_hready <= 1'b0;
            r_hresp  <= RespErr;
            r_pend   <= 1'b0;
          end else if (w_accept) begin
            r_pend  <= 1'b1;
            r_write <= hwrite;
            r_size  <= hsize[1:0];
            r_lane  <= haddr[1:0];
            r_idx   <= w_offset[AW+1:2];
            r_hresp <= RespOkay;
            if (w_wait_cnt == 4'd0) begin
              r_state  <= StIdle;
              r_hready <= 1'b1;
            end else begin
              r_state  <= StWait;
              r_cnt    <= w_wait_cnt;
              r_hready <= 1'b0;
            end
          end else begin
            r_state  <= StIdle;
            r_hready <= 1'b1;
            r_hresp  <= RespOkay;
            r_pend   <= 1'b0;
          end
        end
        StWait: begin
          if (r_cnt <= 4'd1) begin
            r_state  <= StIdle;
            r_cnt    <= 4'd0;
            r_hready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StErr1: begin
          r_state  <= StErr2;
          r_hready <= 1'b1;
          r_hresp  <= RespErr;
        end
        default: begin
          r_state  <= StIdle;
          r_hready <= 1'b1;
          r_hresp  <= RespOkay;
          r_pend   <= 1'b0;
        end
      endcase
    end
  end

  // Write commit on the completion edge; reset suppresses the write.
  always_ff @(posedge hclk) begin
    if (!hreset && w_complete && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

  // Read data comes straight from the array, so a read issued right behind a
  // write to the same word already sees the committed merge.
  assign hrdata = (r_pend && !r_write && r_hready) ? r_mem[r_idx] : 32'h0;
  assign hready = r_hready;
  assign hresp  = r_hresp;

  assign w_unused = ^{hburst, hmaster, hmastlock, htrans[0], w_offset[31:AW+2]};

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed self-checking bench for ahb_mem_slave: a zero-wait instance at
// base 0x1000 and a three-wait instance at base 0.
module tb_ahb_mem_slave;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel0, hsel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata;
  logic [3:0]  hmaster = 4'd0;
  logic        hmastlock = 1'b0;
  logic        hready0, hready1;
  logic [1:0]  hresp0, hresp1;
  logic [31:0] hrdata0, hrdata1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 hclk = ~hclk;

  ahb_mem_slave #(
    .BASE_ADDR  (32'h0000_1000),
    .MEM_DEPTH  (256),
    .WAIT_STATES(0)
  ) u_dut0 (
    .hclk     (hclk),
    .hreset   (hreset),
    .hsel     (hsel0),
    .haddr    (haddr),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hsize    (hsize),
    .hburst   (hburst),
    .hwdata   (hwdata),
    .hmaster  (hmaster),
    .hmastlock(hmastlock),
    .hready_in(hready0),
    .hready   (hready0),
    .hresp    (hresp0),
    .hrdata   (hrdata0)
  );

  ahb_mem_slave #(
    .BASE_ADDR  (32'h0000_0000),
    .MEM_DEPTH  (256),
    .WAIT_STATES(3)
  ) u_dut1 (
    .hclk     (hclk),
    .hreset   (hreset),
    .hsel     (hsel1),
    .haddr    (haddr),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hsize    (hsize),
    .hburst   (hburst),
    .hwdata   (hwdata),
    .hmaster  (hmaster),
    .hmastlock(hmastlock),
    .hready_in(hready1),
    .hready   (hready1),
    .hresp    (hresp1),
    .hrdata   (hrdata1)
  );

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr_ph(input int d, input logic [31:0] a, input logic w, input logic [2:0] sz);
    hsel0  = (d == 0);
    hsel1  = (d == 1);
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    htrans = 2'd2;
  endtask

  task automatic idle_ph();
    hsel0  = 1'b0;
    hsel1  = 1'b0;
    htrans = 2'd0;
    hwrite = 1'b0;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    hwdata = 32'h0;
    addr_ph(0, 32'h0000_1000, 1'b1, 3'd2);
    tick();
    tick();
    @(negedge hclk);
    n_checks++; if (hready0 !== 1'b1) begin n_errors++; $display("FAIL rst_hready0: got %b want 1", hready0); end
    n_checks++; if (hresp0 !== 2'b00) begin n_errors++; $display("FAIL rst_hresp0: got %h want 0", hresp0); end
    n_checks++; if (hrdata0 !== 32'h0) begin n_errors++; $display("FAIL rst_hrdata0: got %h want 0", hrdata0); end
    n_checks++; if (hready1 !== 1'b1) begin n_errors++; $display("FAIL rst_hready1: got %b want 1", hready1); end
    n_checks++; if (hresp1 !== 2'b00) begin n_errors++; $display("FAIL rst_hresp1: got %h want 0", hresp1); end
    n_checks++; if (hrdata1 !== 32'h0) begin n_errors++; $display("FAIL rst_hrdata1: got %h want 0", hrdata1); end
    idle_ph();
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    tick();
  endtask

  task automatic test_word_rw();
    addr_ph(0, 32'h0000_1010, 1'b1, 3'd2);
    tick();
    hwdata = 32'hDEAD_BEEF;
    idle_ph();
    @(negedge hclk);
    n_checks++; if (hready0 !== 1'b1) begin n_errors++; $display("FAIL word_wr_hready: got %b want 1", hready0); end
    tick();
    addr_ph(0, 32'h0000_1010, 1'b0, 3'd2);
    tick();
    idle_ph();
    @(negedge hclk);
    n_checks++; if (hrdata0 !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL word_rd_data: got %h want deadbeef", hrdata0); end
    n_checks++; if (hready0 !== 1'b1) begin n_errors++; $display("FAIL word_rd_hready: got %b want 1", hready0); end
    n_checks++; if (hresp0 !== 2'b00) begin n_errors++; $display("FAIL word_rd_hresp: got %h want 0", hresp0); end
    tick();
    @(negedge hclk);
    n_checks++; if (hrdata0 !== 32'h0) begin n_errors++; $display("FAIL word_rd_idle_data: got %h want 0", hrdata0); end
    tick();
  endtask

  task automatic test_lanes();
    addr_ph(0, 32'h0000_1020, 1'b1, 3'd2);
    tick();
    hwdata = 32'h0;
    addr_ph(0, 32'h0000_1021, 1'b1, 3'd0);
    tick();
    hwdata = 32'h0000_1100;
    addr_ph(0, 32'h0000_1022, 1'b1, 3'd1);
    tick();
    hwdata = 32'hA5A5_0000;
    addr_ph(0, 32'h0000_1020, 1'b0, 3'd2);
    tick();
    hwdata = 32'h0;
    idle_ph();
    @(negedge hclk);
    n_checks++; if (hrdata0 !== 32'hA5A5_1100) begin n_errors++; $display("FAIL lanes_data: got %h want a5a51100", hrdata0); end
    tick();
  endtask

  task automatic test_forward();
    addr_ph(0, 32'h0000_1040, 1'b1, 3'd2);
    tick();
    hwdata = 32'h1234_5678;
    addr_ph(0, 32'h0000_1040, 1'b0, 3'd2);
    tick();
    idle_ph();
    @(negedge hclk);
    n_checks++; if (hrdata0 !== 32'h1234_5678) begin n_errors++; $display("FAIL fwd_data: got %h want 12345678", hrdata0); end
    n_checks++; if (hresp0 !== 2'b00) begin n_errors++; $display("FAIL fwd_hresp: got %h want 0", hresp0); end
    tick();
  endtask

  task automatic test_error();
    logic [31:0] ea [5];
    logic [2:0]  es [5];
    ea[0] = 32'h0000_1002; es[0] = 3'd2;
    ea[1] = 32'h0000_1400; es[1] = 3'd2;
    ea[2] = 32'h0000_0FFC; es[2] = 3'd2;
    ea[3] = 32'h0000_1001; es[3] = 3'd1;
    ea[4] = 32'h0000_1000; es[4] = 3'd3;
    addr_ph(0, 32'h0000_1000, 1'b1, 3'd2);
    tick();
    hwdata = 32'h600D_F00D;
    idle_ph();
    tick();
    for (int i = 0; i < 5; i++) begin
      addr_ph(0, ea[i], 1'b1, es[i]);
      tick();
      hwdata = 32'hFFFF_FFFF;
      idle_ph();
      @(negedge hclk);
      n_checks++; if (hready0 !== 1'b0 || hresp0 !== 2'b01) begin
        n_errors++; $display("FAIL err1_%0d: got hready=%b hresp=%h want 0/1", i, hready0, hresp0);
      end
      @(posedge hclk);
      #1;
      if (i == 4) addr_ph(0, 32'h0000_1000, 1'b0, 3'd2);
      @(negedge hclk);
      n_checks++; if (hready0 !== 1'b1 || hresp0 !== 2'b01) begin
        n_errors++; $display("FAIL err2_%0d: got hready=%b hresp=%h want 1/1", i, hready0, hresp0);
      end
      tick();
      idle_ph();
    end
    @(negedge hclk);
    n_checks++; if (hrdata0 !== 32'h600D_F00D) begin n_errors++; $display("FAIL err_mem_kept: got %h want 600df00d", hrdata0); end
    n_checks++; if (hresp0 !== 2'b00) begin n_errors++; $display("FAIL err_after_hresp: got %h want 0", hresp0); end
    tick();
  endtask

  task automatic test_idle_busy();
    addr_ph(1, 32'h0000_0100, 1'b0, 3'd2);
    htrans = 2'd1;
    tick();
    @(negedge hclk);
    n_checks++; if (hready1 !== 1'b1) begin n_errors++; $display("FAIL busy_hready: got %b want 1", hready1); end
    htrans = 2'd2;
    hsel1  = 1'b0;
    tick();
    @(negedge hclk);
    n_checks++; if (hready1 !== 1'b1 || hrdata1 !== 32'h0) begin
      n_errors++; $display("FAIL nosel: got hready=%b hrdata=%h want 1/0", hready1, hrdata1);
    end
    idle_ph();
    tick();
  endtask

  task automatic test_wait();
    int n;
    int nz;
    addr_ph(1, 32'h0000_0100, 1'b1, 3'd2);
    tick();
    hwdata = 32'hCAFE_F00D;
    idle_ph();
    n = 0;
    @(negedge hclk);
    while (hready1 !== 1'b1 && n < 20) begin n++; @(negedge hclk); end
    n_checks++; if (n !== 3) begin n_errors++; $display("FAIL wait_wr_cycles: got %0d want 3", n); end
    tick();
    addr_ph(1, 32'h0000_0100, 1'b0, 3'd2);
    tick();
    idle_ph();
    n  = 0;
    nz = 0;
    @(negedge hclk);
    while (hready1 !== 1'b1 && n < 20) begin
      if (hrdata1 !== 32'h0) nz++;
      n++;
      @(negedge hclk);
    end
    n_checks++; if (n !== 3) begin n_errors++; $display("FAIL wait_rd_cycles: got %0d want 3", n); end
    n_checks++; if (nz !== 0) begin n_errors++; $display("FAIL wait_rd_early_data: got %0d nonzero want 0", nz); end
    n_checks++; if (hrdata1 !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL wait_rd_data: got %h want cafef00d", hrdata1); end
    n_checks++; if (hresp1 !== 2'b00) begin n_errors++; $display("FAIL wait_rd_hresp: got %h want 0", hresp1); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    int n;
    addr_ph(1, 32'h0000_0104, 1'b1, 3'd2);
    tick();
    hwdata = 32'h1111_1111;
    idle_ph();
    n = 0;
    @(negedge hclk);
    while (hready1 !== 1'b1 && n < 20) begin n++; @(negedge hclk); end
    tick();
    addr_ph(1, 32'h0000_0104, 1'b1, 3'd2);
    tick();
    hwdata = 32'h2222_2222;
    idle_ph();
    tick();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    @(negedge hclk);
    n_checks++; if (hready1 !== 1'b1 || hresp1 !== 2'b00 || hrdata1 !== 32'h0) begin
      n_errors++; $display("FAIL rstwait_outputs: got hready=%b hresp=%h hrdata=%h want 1/0/0", hready1, hresp1, hrdata1);
    end
    tick();
    addr_ph(1, 32'h0000_0104, 1'b0, 3'd2);
    tick();
    idle_ph();
    n = 0;
    @(negedge hclk);
    while (hready1 !== 1'b1 && n < 20) begin n++; @(negedge hclk); end
    n_checks++; if (n !== 3) begin n_errors++; $display("FAIL rstwait_rd_cycles: got %0d want 3", n); end
    n_checks++; if (hrdata1 !== 32'h1111_1111) begin n_errors++; $display("FAIL rstwait_mem_kept: got %h want 11111111", hrdata1); end
    tick();
  endtask

  initial begin
    hsel0  = 1'b0;
    hsel1  = 1'b0;
    haddr  = 32'h0;
    htrans = 2'd0;
    hwrite = 1'b0;
    hsize  = 3'd2;
    hwdata = 32'h0;
    hreset = 1'b1;
    test_reset();
    test_word_rw();
    test_lanes();
    test_forward();
    test_error();
    test_idle_busy();
    test_wait();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
